// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline register: control/entry records, stage state, counter limit.
// Imported by ex_mem_pipe_stage and pipe_sat_counter.
package ex_mem_pkg;

  localparam int unsigned EX_MEM_DATA_W = 32;
  localparam int unsigned EX_MEM_REG_W  = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    ex_mem_ctrl_t              ctrl;
    logic [EX_MEM_DATA_W-1:0]  alu_out;
    logic [EX_MEM_DATA_W-1:0]  write_data;
    logic [EX_MEM_REG_W-1:0]   write_reg;
  } ex_mem_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_FULL_SKID = 2'd2
  } ex_mem_state_e;

  // Counters saturate at all-ones; each counter slices this to its own width (up to 64 bits).
  localparam logic [63:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module pipe_sat_counter
  import ex_mem_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] SAT = CNT_SAT_ALL[CNT_W-1:0];

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != SAT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, flush and stall/bubble counters.
// Define EX_MEM_SKID_EN for a one-entry skid slot with a registered in_ready.
module ex_mem_pipe_stage
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = EX_MEM_DATA_W,
  parameter int unsigned REG_W  = EX_MEM_REG_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              mem_write_e,
  input  logic [DATA_W-1:0] alu_out_e,
  input  logic [DATA_W-1:0] write_data_e,
  input  logic [REG_W-1:0]  write_reg_e,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reg_write_m,
  output logic              mem_to_reg_m,
  output logic              mem_write_m,
  output logic [DATA_W-1:0] alu_out_m,
  output logic [DATA_W-1:0] write_data_m,
  output logic [REG_W-1:0]  write_reg_m,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Same layout as ex_mem_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    ex_mem_ctrl_t      ctrl;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  write_reg;
  } entry_t;

  ex_mem_state_e state_q, state_d;
  entry_t        out_q, out_d;
  entry_t        in_entry;
  logic          in_xfer, out_xfer;

`ifdef EX_MEM_SKID_EN
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
`endif

  always_comb begin
    in_entry                 = '0;
    in_entry.ctrl.reg_write  = reg_write_e;
    in_entry.ctrl.mem_to_reg = mem_to_reg_e;
    in_entry.ctrl.mem_write  = mem_write_e;
    in_entry.alu_out         = alu_out_e;
    in_entry.write_data      = write_data_e;
    in_entry.write_reg       = write_reg_e;
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
`ifdef EX_MEM_SKID_EN
      skid_q     <= '0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
`ifdef EX_MEM_SKID_EN
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_FULL;
      ST_FULL: begin
        if (out_xfer && !in_xfer) state_d = ST_EMPTY;
`ifdef EX_MEM_SKID_EN
        else if (!out_xfer && in_xfer) state_d = ST_FULL_SKID;
`endif
      end
`ifdef EX_MEM_SKID_EN
      ST_FULL_SKID: if (out_xfer) state_d = ST_FULL;
`endif
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // Entry movement; an entry accepted during flush is dropped, held data stays put
  always_comb begin
    out_d = out_q;
`ifdef EX_MEM_SKID_EN
    skid_d     = skid_q;
    in_ready_d = (state_d != ST_FULL_SKID);
`endif
    if (!flush) begin
      if (state_q == ST_FULL_SKID) begin
`ifdef EX_MEM_SKID_EN
        if (out_xfer) out_d = skid_q;
`endif
      end else if (in_xfer) begin
        if ((state_q == ST_EMPTY) || out_xfer) begin
          out_d = in_entry;
        end
`ifdef EX_MEM_SKID_EN
        else begin
          skid_d = in_entry;
        end
`endif
      end
    end
  end

  // Outputs; write enables are gated so a bubble never writes
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
`ifdef EX_MEM_SKID_EN
    in_ready = in_ready_q;
`else
    in_ready = ~out_valid | out_ready;
`endif
    reg_write_m  = out_valid & out_q.ctrl.reg_write;
    mem_write_m  = out_valid & out_q.ctrl.mem_write;
    mem_to_reg_m = out_q.ctrl.mem_to_reg;
    alu_out_m    = out_q.alu_out;
    write_data_m = out_q.write_data;
    write_reg_m  = out_q.write_reg;
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .clear (cnt_clear),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (~out_valid),
    .clear (cnt_clear),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: directed table, corner-case sequences and random traffic vs a queue model.
module tb_ex_mem_pipe_stage;

  localparam int CMAX = 15;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
  } ent_t;

  typedef struct {
    logic        iv, ordy, fl, clr;
    ent_t        e;
    logic        xv;
    logic [31:0] xalu;
    logic        xrw, xmw;
    logic [4:0]  xwr;
    int          xst, xbb;
  } vec_t;

  logic        clock, reset, flush, in_valid, in_ready, out_valid, out_ready, cnt_clear;
  logic        reg_write_e, mem_to_reg_e, mem_write_e;
  logic        reg_write_m, mem_to_reg_m, mem_write_m;
  logic [31:0] alu_out_e, write_data_e, alu_out_m, write_data_m;
  logic [4:0]  write_reg_e, write_reg_m;
  logic [3:0]  stall_cnt, bubble_cnt;

  int checks   = 0;
  int failures = 0;

  ent_t q[$];
  ent_t shown;
  int   st_m, bb_m;

  ex_mem_pipe_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m),
    .alu_out_m(alu_out_m), .write_data_m(write_data_m), .write_reg_m(write_reg_m),
    .cnt_clear(cnt_clear), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic ent_t mk(input logic rw, input logic mtr, input logic mw,
                              input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    ent_t e;
    e.rw = rw; e.mtr = mtr; e.mw = mw; e.alu = alu; e.wd = wd; e.wr = wr;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    shown = '0;
    st_m  = 0;
    bb_m  = 0;
  endtask

  task automatic check_outs();
    logic v;
    v = (q.size() > 0);
    chk("out_valid",    out_valid,    v);
    chk("reg_write_m",  reg_write_m,  v & shown.rw);
    chk("mem_write_m",  mem_write_m,  v & shown.mw);
    chk("mem_to_reg_m", mem_to_reg_m, shown.mtr);
    chk("alu_out_m",    alu_out_m,    shown.alu);
    chk("write_data_m", write_data_m, shown.wd);
    chk("write_reg_m",  write_reg_m,  shown.wr);
    chk("stall_cnt",    stall_cnt,    st_m);
    chk("bubble_cnt",   bubble_cnt,   bb_m);
  endtask

  // One clock: drive at edge+1, check in_ready before the edge, advance model, check at edge+1.
  task automatic step(input logic iv, input logic ordy, input logic fl, input logic clr, input ent_t e);
    logic exp_rdy, ov, ix, ox;
    in_valid = iv; out_ready = ordy; flush = fl; cnt_clear = clr;
    reg_write_e = e.rw; mem_to_reg_e = e.mtr; mem_write_e = e.mw;
    alu_out_e = e.alu; write_data_e = e.wd; write_reg_e = e.wr;
    #1;
`ifdef EX_MEM_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || ordy;
`endif
    chk("in_ready", in_ready, exp_rdy);
    ov = (q.size() > 0);
    ix = iv && exp_rdy;
    ox = ov && ordy;
    @(posedge clock);
    if (clr) begin
      st_m = 0;
      bb_m = 0;
    end else begin
      if (ov && !ordy && st_m < CMAX) st_m++;
      if (!ov && bb_m < CMAX) bb_m++;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(e);
    end
    if (q.size() > 0) shown = q[0];
    #1;
    check_outs();
  endtask

  vec_t tbl[10];
  ent_t idle;

  initial begin
    idle = '0;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 32'h1234, 32'h0, 5'd5),          1'b1, 32'h1234, 1'b1, 1'b0, 5'd5,  0, 1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, mk(0, 1, 1, 32'h1111, 32'h2222, 5'd6),       1'b1, 32'h1111, 1'b0, 1'b1, 5'd6,  0, 1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, idle,                                        1'b1, 32'h1111, 1'b0, 1'b1, 5'd6,  1, 1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, idle,                                        1'b1, 32'h1111, 1'b0, 1'b1, 5'd6,  2, 1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, idle,                                        1'b0, 32'h1111, 1'b0, 1'b0, 5'd6,  2, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, idle,                                        1'b0, 32'h1111, 1'b0, 1'b0, 5'd6,  2, 2};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 32'hAAAA, 32'h5555, 5'd31),      1'b1, 32'hAAAA, 1'b1, 1'b1, 5'd31, 2, 3};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, mk(1, 1, 1, 32'hBBBB, 32'h0, 5'd7),          1'b0, 32'hAAAA, 1'b0, 1'b0, 5'd31, 3, 3};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, idle,                                        1'b0, 32'hAAAA, 1'b0, 1'b0, 5'd31, 3, 4};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, idle,                                        1'b0, 32'hAAAA, 1'b0, 1'b0, 5'd31, 0, 0};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
    reg_write_e = 1'b0; mem_to_reg_e = 1'b0; mem_write_e = 1'b0;
    alu_out_e = '0; write_data_e = '0; write_reg_e = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid",  out_valid,  1'b0);
    chk("rst_in_ready",   in_ready,   1'b1);
    chk("rst_alu_out_m",  alu_out_m,  32'h0);
    chk("rst_write_reg",  write_reg_m, 5'd0);
    chk("rst_stall_cnt",  stall_cnt,  4'd0);
    chk("rst_bubble_cnt", bubble_cnt, 4'd0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].clr, tbl[i].e);
      chk($sformatf("tbl%0d_out_valid", i),   out_valid,   tbl[i].xv);
      chk($sformatf("tbl%0d_alu_out_m", i),   alu_out_m,   tbl[i].xalu);
      chk($sformatf("tbl%0d_reg_write_m", i), reg_write_m, tbl[i].xrw);
      chk($sformatf("tbl%0d_mem_write_m", i), mem_write_m, tbl[i].xmw);
      chk($sformatf("tbl%0d_write_reg_m", i), write_reg_m, tbl[i].xwr);
      chk($sformatf("tbl%0d_stall_cnt", i),   stall_cnt,   tbl[i].xst);
      chk($sformatf("tbl%0d_bubble_cnt", i),  bubble_cnt,  tbl[i].xbb);
    end

    // Stall with EX still presenting entries
    step(1, 1, 0, 1, mk(1, 0, 0, 32'hC0DE, 32'h1, 5'd5));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, mk(0, 0, 1, 32'hD000 + i, 32'h2, 5'd9));
    chk("stall_hold_alu", alu_out_m, 32'hC0DE);
    chk("stall_hold_rw",  reg_write_m, 1'b1);
    chk("stall_hold_wr",  write_reg_m, 5'd5);
    chk("stall_cnt3",     stall_cnt, 4'd3);
    chk("stall_in_ready", in_ready, 1'b0);
    step(0, 1, 0, 0, idle);
`ifdef EX_MEM_SKID_EN
    chk("skid_promote", alu_out_m, 32'hD000);
`else
    chk("noskid_drain", out_valid, 1'b0);
`endif
    step(0, 1, 0, 0, idle);
    chk("drained", out_valid, 1'b0);

    // Back-to-back stream of 8
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, (i == 0), mk(i[0], 1, 0, 32'd100 + i, 32'd200 + i, 5'(i)));
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_order", alu_out_m, 32'd100 + i);
    end
    step(0, 1, 0, 0, idle);
    chk("stream_no_bubble", bubble_cnt, 4'd0);

    // Counter saturation and clear
    step(0, 1, 0, 1, idle);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, idle);
    chk("bubble_sat", bubble_cnt, 4'd15);
    step(0, 1, 0, 1, idle);
    chk("bubble_clear", bubble_cnt, 4'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
           mk(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom)));
    end

    // Asynchronous reset in the middle of a stall
    step(1, 0, 0, 0, mk(1, 1, 1, 32'hFEED, 32'hBEEF, 5'd5));
    step(0, 0, 0, 0, idle);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid",  out_valid,   1'b0);
    chk("arst_alu_out_m",  alu_out_m,   32'h0);
    chk("arst_wdata_m",    write_data_m, 32'h0);
    chk("arst_write_reg",  write_reg_m, 5'd0);
    chk("arst_mem_to_reg", mem_to_reg_m, 1'b0);
    chk("arst_stall_cnt",  stall_cnt,   4'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("arst_in_ready", in_ready, 1'b1);
    step(1, 1, 0, 0, mk(0, 0, 0, 32'h77, 32'h88, 5'd3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
